// File: rtl/zcd_window_packetizer.sv
// zcd_window_packetizer: gates the ADC sample stream with the zero-crossing detector's capture
// window, forms packets that begin on a zero crossing, and streams them out through a
// first-word-fall-through FIFO as an AXI-Stream master with tlast on the final sample.
module zcd_window_packetizer #(
    parameter int unsigned DATA_WIDTH = 46,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_data_valid,
    input  logic                  in_save,
    input  logic                  in_start,
    input  logic [REG_WIDTH-1:0]  max_packet,
    input  logic                  clear_status,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [REG_WIDTH-3:0]  out_counter_pos,
    output logic [REG_WIDTH-1:0]  packet_len,
    output logic [REG_WIDTH-1:0]  packet_count,
    output logic                  overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_FLUSH   = 2'd3;

    localparam logic [REG_WIDTH-1:0] CNT_SAT = '1;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_v_q, hold_v_d;
    logic [REG_WIDTH-1:0]  count_q, count_d;
    logic [REG_WIDTH-1:0]  packet_len_q, packet_len_d;
    logic [REG_WIDTH-1:0]  packet_count_q, packet_count_d;
    logic                  overflow_q, overflow_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;

    logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem_q;

    logic          push;
    logic          push_last;
    logic          end_evt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          mem_we;
    logic          drop;
    logic          fix_last;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] tail_idx;

    // Capture FSM: hold one sample back so tlast can be attached once the end is known.
    always_comb begin
        state_d        = state_q;
        hold_data_d    = hold_data_q;
        hold_v_d       = hold_v_q;
        count_d        = count_q;
        packet_len_d   = packet_len_q;
        packet_count_d = packet_count_q;
        push           = 1'b0;
        push_last      = 1'b0;
        end_evt        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (in_save) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!in_save) begin
                    state_d = ST_IDLE;
                end else if (in_start && in_data_valid) begin
                    hold_data_d = in_data;
                    hold_v_d    = 1'b1;
                    count_d     = {{(REG_WIDTH-1){1'b0}}, 1'b1};
                    state_d     = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // The cap compares the already-incremented count, so tlast trails the
                // capping sample by one cycle and a sample in this cycle is discarded.
                end_evt = !in_save || ((max_packet != '0) && (count_q == max_packet));
                if (end_evt) begin
                    push           = hold_v_q;
                    push_last      = 1'b1;
                    hold_v_d       = 1'b0;
                    packet_len_d   = count_q;
                    packet_count_d = packet_count_q + 1'b1;
                    state_d        = ST_FLUSH;
                end else if (in_data_valid) begin
                    push        = hold_v_q;
                    hold_data_d = in_data;
                    hold_v_d    = 1'b1;
                    if (count_q != CNT_SAT) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                // A capped packet waits here until the window closes.
                if (!in_save) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear wins over a same-cycle packet completion.
        if (clear_status) begin
            packet_count_d = '0;
        end
    end

    // FIFO control: push/pop bookkeeping, drop-on-full and sticky overflow.
    always_comb begin
        wr_idx     = wr_ptr_q[AW-1:0];
        rd_idx     = rd_ptr_q[AW-1:0];
        tail_idx   = wr_idx - {{(AW-1){1'b0}}, 1'b1};
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
        pop        = !fifo_empty && m_axis_tready;
        // A pop frees the slot the push lands in, so full+pop still accepts the push.
        mem_we     = push && (!fifo_full || pop);
        drop       = push && fifo_full && !pop;
        // A dropped terminator moves tlast onto the newest stored entry.
        fix_last   = drop && push_last;
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, mem_we};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};

        overflow_d = clear_status ? 1'b0 : overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // State and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            hold_data_q    <= '0;
            hold_v_q       <= 1'b0;
            count_q        <= '0;
            packet_len_q   <= '0;
            packet_count_q <= '0;
            overflow_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            hold_data_q    <= hold_data_d;
            hold_v_q       <= hold_v_d;
            count_q        <= count_d;
            packet_len_q   <= packet_len_d;
            packet_count_q <= packet_count_d;
            overflow_q     <= overflow_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            data_mem_q[wr_idx] <= hold_data_q;
            last_mem_q[wr_idx] <= push_last;
        end
        if (fix_last) begin
            last_mem_q[tail_idx] <= 1'b1;
        end
    end

    // Outputs are forced to zero while the FIFO is empty so reset shows all zeros.
    always_comb begin
        m_axis_tvalid   = !fifo_empty;
        m_axis_tdata    = fifo_empty ? '0 : data_mem_q[rd_idx];
        m_axis_tlast    = fifo_empty ? 1'b0 : last_mem_q[rd_idx];
        out_counter_pos = ((state_q == ST_CAPTURE) || (state_q == ST_FLUSH)) ?
                          count_q[REG_WIDTH-3:0] : '0;
        packet_len      = packet_len_q;
        packet_count    = packet_count_q;
        overflow        = overflow_q;
    end

endmodule

// File: tb/tb_zcd_window_packetizer.sv
// Bench for zcd_window_packetizer: directed scenarios plus randomized windows, checked
// against a packet-level reference model (sample queue + packet length queue).
module tb_zcd_window_packetizer;

    localparam int unsigned DW = 46;
    localparam int unsigned RW = 32;
    localparam int unsigned FD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_data_valid;
    logic          in_save;
    logic          in_start;
    logic [RW-1:0] max_packet;
    logic          clear_status;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [RW-3:0] out_counter_pos;
    logic [RW-1:0] packet_len;
    logic [RW-1:0] packet_count;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0] exp_q[$];
    int unsigned   plen_q[$];
    int unsigned   out_idx;
    bit            model_en;
    bit            m_cap;
    bit            m_done;
    bit            m_prev_save;
    int unsigned   m_pkt_cnt;
    int unsigned   m_len;
    int unsigned   m_count;
    bit            stall_v;
    logic [DW-1:0] stall_data;
    logic          stall_last;

    always #5 clk = ~clk;

    zcd_window_packetizer #(
        .DATA_WIDTH(DW),
        .REG_WIDTH (RW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_data_valid  (in_data_valid),
        .in_save        (in_save),
        .in_start       (in_start),
        .max_packet     (max_packet),
        .clear_status   (clear_status),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .out_counter_pos(out_counter_pos),
        .packet_len     (packet_len),
        .packet_count   (packet_count),
        .overflow       (overflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        plen_q.delete();
        out_idx     = 0;
        m_cap       = 0;
        m_done      = 0;
        m_prev_save = 0;
        m_pkt_cnt   = 0;
        m_len       = 0;
        m_count     = 0;
        stall_v     = 0;
    endtask

    // Packet rules: capture starts on start+valid once the window has been open a cycle,
    // ends on window close or when the packet already holds max_packet samples.
    task automatic model_step();
        if (m_done) begin
            if (!in_save) m_done = 0;
        end else if (m_cap) begin
            if (!in_save || (max_packet != 0 && m_pkt_cnt == max_packet)) begin
                plen_q.push_back(m_pkt_cnt);
                m_len   = m_pkt_cnt;
                m_count = m_count + 1;
                m_cap   = 0;
                m_done  = 1;
            end else if (in_data_valid) begin
                exp_q.push_back(in_data);
                m_pkt_cnt++;
            end
        end else if (in_save && m_prev_save && in_start && in_data_valid) begin
            m_cap     = 1;
            m_pkt_cnt = 1;
            exp_q.push_back(in_data);
        end
        if (clear_status) m_count = 0;
        m_prev_save = in_save;
    endtask

    task automatic check_beat();
        logic [DW-1:0] d;
        logic          el;
        if (exp_q.size() == 0) begin
            check_eq("beat_spurious", 64'(m_axis_tvalid), 64'd0);
        end else begin
            d  = exp_q.pop_front();
            el = (plen_q.size() > 0) && (out_idx + 1 == plen_q[0]);
            check_eq("beat_data", 64'(m_axis_tdata), 64'(d));
            check_eq("beat_last", 64'(m_axis_tlast), 64'(el));
            if (el) begin
                void'(plen_q.pop_front());
                out_idx = 0;
            end else begin
                out_idx++;
            end
        end
    endtask

    task automatic check_status();
        int unsigned pos;
        pos = (m_cap || m_done) ? (m_pkt_cnt & 32'h3FFF_FFFF) : 0;
        check_eq("pos", 64'(out_counter_pos), 64'(pos));
        check_eq("plen", 64'(packet_len), 64'(m_len));
        check_eq("pcnt", 64'(packet_count), 64'(m_count));
        check_eq("ovf", 64'(overflow), 64'd0);
    endtask

    // One clock: called at a negedge with inputs already driven.
    task automatic cycle();
        if (model_en) begin
            if (stall_v) begin
                check_eq("stall_valid", 64'(m_axis_tvalid), 64'd1);
                check_eq("stall_data", 64'(m_axis_tdata), 64'(stall_data));
                check_eq("stall_last", 64'(m_axis_tlast), 64'(stall_last));
            end
            stall_v    = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
            stall_last = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) check_beat();
        end
        @(posedge clk);
        if (model_en) model_step();
        @(negedge clk);
        if (model_en) check_status();
    endtask

    task automatic drive(input logic s, input logic st, input logic v, input logic [DW-1:0] d);
        in_save       = s;
        in_start      = st;
        in_data_valid = v;
        in_data       = d;
        cycle();
    endtask

    task automatic drain();
        int k;
        k = 0;
        m_axis_tready = 1'b1;
        while ((exp_q.size() != 0 || m_axis_tvalid) && k < 200) begin
            drive(1'b0, 1'b0, 1'b0, '0);
            k++;
        end
        check_eq("drain_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("drain_left", 64'(exp_q.size()), 64'd0);
        check_eq("drain_plen_q", 64'(plen_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        in_save       = 1'b0;
        in_start      = 1'b0;
        in_data_valid = 1'b0;
        in_data       = '0;
        clear_status  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [63:0]   r;
        logic [DW-1:0] e;
        int            beats;
        bit            s;

        max_packet    = '0;
        m_axis_tready = 1'b1;
        model_en      = 0;
        do_reset();
        rst = 1'b0;
        #1;
        check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check_eq("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check_eq("rst_pos", 64'(out_counter_pos), 64'd0);
        check_eq("rst_plen", 64'(packet_len), 64'd0);
        check_eq("rst_pcnt", 64'(packet_count), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst      = 1'b1;
        model_en = 1;

        // Basic 10-sample packet
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 46'h10);
        for (int i = 1; i < 10; i++) drive(1'b1, 1'b0, 1'b1, 46'h10 + 46'(i));
        drive(1'b0, 1'b0, 1'b0, '0);
        drain();
        check_eq("basic_len", 64'(packet_len), 64'd10);
        check_eq("basic_cnt", 64'(packet_count), 64'd1);

        // Start gating: start while window closed, start without a valid sample
        drive(1'b0, 1'b1, 1'b1, 46'h77);
        drive(1'b0, 1'b1, 1'b1, 46'h78);
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 46'h79);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, 46'h7A);
        drive(1'b0, 1'b0, 1'b0, '0);
        check_eq("gate_no_out", 64'(m_axis_tvalid), 64'd0);
        check_eq("gate_cnt", 64'(packet_count), 64'd1);

        // Cap at 4 with a long window and a second start that must not re-arm
        max_packet = 4;
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++)
            drive(1'b1, (i == 0 || i == 10), 1'b1, 46'h40 + 46'(i));
        check_eq("cap_len", 64'(packet_len), 64'd4);
        check_eq("cap_cnt", 64'(packet_count), 64'd2);
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 46'h80);
        drive(1'b1, 1'b0, 1'b1, 46'h81);
        drive(1'b0, 1'b0, 1'b0, '0);
        drain();
        check_eq("rearm_len", 64'(packet_len), 64'd2);

        // Window closes in the same cycle as a valid sample
        max_packet = 0;
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 46'h300);
        drive(1'b1, 1'b0, 1'b1, 46'h301);
        drive(1'b1, 1'b0, 1'b1, 46'h302);
        drive(1'b0, 1'b0, 1'b1, 46'h3FF);
        drain();
        check_eq("simul_len", 64'(packet_len), 64'd3);

        // Randomized windows, starts, backpressure and clears
        s = 0;
        for (int ph = 0; ph < 6; ph++) begin
            max_packet = (ph % 3 == 0) ? 0 : $urandom_range(1, 8);
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 11) == 0) s = !s;
                r             = {$urandom(), $urandom()};
                m_axis_tready = ($urandom_range(0, 3) != 0);
                clear_status  = ($urandom_range(0, 63) == 0);
                drive(s, ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 1) == 1) && (exp_q.size() < 12), r[DW-1:0]);
                clear_status = 1'b0;
            end
            s = 0;
            for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 1'b0, '0);
        end
        drain();

        // Backpressure overflow: 30-sample packet into a 16-entry FIFO
        model_en = 0;
        do_reset();
        max_packet    = 0;
        m_axis_tready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 30; i++) drive(1'b1, (i == 0), 1'b1, 46'h500 + 46'(i));
        drive(1'b0, 1'b0, 1'b0, '0);
        check_eq("ovf_flag", 64'(overflow), 64'd1);
        check_eq("ovf_len", 64'(packet_len), 64'd30);
        check_eq("ovf_cnt", 64'(packet_count), 64'd1);
        m_axis_tready = 1'b1;
        beats = 0;
        for (int k = 0; k < 40 && m_axis_tvalid; k++) begin
            e = 46'h500 + 46'(beats);
            check_eq("ovf_beat_data", 64'(m_axis_tdata), 64'(e));
            check_eq("ovf_beat_last", 64'(m_axis_tlast), 64'(beats == 15));
            beats++;
            drive(1'b0, 1'b0, 1'b0, '0);
        end
        check_eq("ovf_beats", 64'(beats), 64'd16);
        clear_status = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        clear_status = 1'b0;
        check_eq("ovf_clear", 64'(overflow), 64'd0);
        check_eq("pcnt_clear", 64'(packet_count), 64'd0);

        // Reset in the middle of a packet, then a clean packet
        do_reset();
        model_en      = 1;
        m_axis_tready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 46'h600);
        for (int i = 1; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 46'h600 + 46'(i));
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("mid_rst_tdata", 64'(m_axis_tdata), 64'd0);
        check_eq("mid_rst_tlast", 64'(m_axis_tlast), 64'd0);
        check_eq("mid_rst_pos", 64'(out_counter_pos), 64'd0);
        check_eq("mid_rst_plen", 64'(packet_len), 64'd0);
        check_eq("mid_rst_pcnt", 64'(packet_count), 64'd0);
        check_eq("mid_rst_ovf", 64'(overflow), 64'd0);
        model_reset();
        in_save       = 1'b0;
        in_start      = 1'b0;
        in_data_valid = 1'b0;
        @(negedge clk);
        rst           = 1'b1;
        m_axis_tready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 46'h700);
        for (int i = 1; i < 6; i++) drive(1'b1, 1'b0, 1'b1, 46'h700 + 46'(i));
        drive(1'b0, 1'b0, 1'b0, '0);
        drain();
        check_eq("post_rst_len", 64'(packet_len), 64'd6);
        check_eq("post_rst_cnt", 64'(packet_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
